cache_dfp_arbiter: RTL and testbench
====================================

// Module: cache_dfp_arbiter
// PURPOSE
//  Shares one cacheline_adapter upward port between the I-cache and D-cache DFPs.
//  Grants one cache at a time and holds the grant for a full 256-bit line read or
//  write until the adapter responds. Routes the response back to the granted cache only.
//  Sits between the pipelined caches and cacheline_adapter in the mp_ooo memory subsystem.
// PARAMETERS
//  ADDR_WIDTH  32   byte address width
//  DATA_WIDTH  256  cacheline width (bits)
// PORTS
//  clk           in   1           clock, all state on posedge
//  rst           in   1           reset: one clock; reset is asynchronous and active-low
//  i_dfp_addr    in   ADDR_WIDTH  I-cache line address
//  i_dfp_read    in   1           I-cache line read request (level, held until resp)
//  i_dfp_write   in   1           I-cache line write request (level, held until resp)
//  i_dfp_wdata   in   DATA_WIDTH  I-cache write line
//  i_dfp_rdata   out  DATA_WIDTH  read line (broadcast of mem_rdata)
//  i_dfp_resp    out  1           I-cache completion pulse
//  d_dfp_*       same set as i_dfp_*, for the D-cache
//  mem_addr      out  ADDR_WIDTH  to adapter ufp_addr, low 5 bits forced to 0
//  mem_read      out  1           to adapter ufp_read
//  mem_write     out  1           to adapter ufp_write
//  mem_wdata     out  DATA_WIDTH  to adapter ufp_wdata
//  mem_rdata     in   DATA_WIDTH  from adapter ufp_rdata
//  mem_resp      in   1           from adapter ufp_resp
//  arb_busy      out  1           1 while in GRANT_I or GRANT_D
//  arb_owner     out  1           0 = I-cache, 1 = D-cache; last/current grant
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, rr_last=0 (I), arb_owner=0. All mem_* and
//    *_resp outputs are 0. *_rdata outputs mirror mem_rdata combinationally.
//  - FSM states are IDLE, GRANT_I and GRANT_D, with a registered state.
//    IDLE -> GRANT_x on posedge when requester x has read|write and wins arbitration.
//    GRANT_x -> IDLE on posedge when mem_resp=1. A grant never switches mid-transaction.
//  - Arbitration applies only in IDLE. If only one requester is active, that one wins.
//    If both are active, the winner is picked per CONFIGURATION.
//  - Outputs in GRANT_x (combinational from registered state):
//    mem_addr = x_addr & ~32'h1F; mem_read/write/wdata = x's.
//    x_resp = mem_resp; the other resp = 0.
//  - Outputs in IDLE: mem_read=mem_write=0, mem_addr=0, mem_wdata=0, both resp=0.
//  - Latency: a request seen in IDLE at edge N drives mem_* from cycle N+1. The adapter
//    resp passes through with 0 cycles. One mandatory IDLE bubble follows each resp, so
//    a cache that drops its request on resp is never re-granted stale.
//  - mem_resp in IDLE is ignored and not forwarded.
//  - If a requester drops read/write mid-grant, the grant is still held until mem_resp.
//    mem_read/write follow the requester's live level.
//  - A requester asserting read and write together is illegal. Both are forwarded
//    unchanged, and an assertion fires in simulation.
//  - rr_last updates to the granted requester on the IDLE->GRANT edge.
//  - Reset mid-grant returns to IDLE immediately and all outputs drop. The adapter is
//    reset together with the arbiter.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined: on a tie, grant the requester not equal to rr_last
//    (alternates I/D).
//  ARB_ROUND_ROBIN_EN undefined: fixed priority; on a tie the D-cache always wins.
//    rr_last is still kept and drives arb_owner.
// TESTING
//  1 Reset: hold rst=0 for 3 cycles with random inputs -> mem_read=mem_write=0,
//    both resp=0, arb_busy=0.
//  2 I read only: i_addr=32'h1eceb004, i_read=1, adapter resp after 10 cycles ->
//    mem_addr=32'h1eceb000 from next cycle, i_resp pulses 1 cycle, d_resp stays 0,
//    i_rdata=mem_rdata.
//  3 D write only: d_addr=32'h0000_1040, d_wdata={8{32'hdeadbeef}} ->
//    mem_write=1, mem_wdata matches, d_resp on adapter resp, then FSM back to IDLE.
//  4 Tie: i_read and d_read together, 3 back-to-back rounds ->
//    with RR on, grants are D,I,D (rr_last=0 at start); with RR off, all go to D.
//    A 1-cycle IDLE gap appears between grants.
//  5 Late arrival: d_read rises while I is granted -> I completes uninterrupted,
//    and D is granted the cycle after the IDLE bubble.
//  6 Reset mid-grant: assert rst during GRANT_D ->
//    same cycle mem_read=0, arb_busy=0; after release, the pending request is re-granted.

Source files
------------

// File: rtl/cache_dfp_arbiter_if.sv
// Bundle of the I-cache DFP, D-cache DFP and adapter-side signals around cache_dfp_arbiter.
// The slave modport is the arbiter's view; master is the view of the caches and adapter.
interface cache_dfp_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256
);
  logic [ADDR_WIDTH-1:0] i_dfp_addr;
  logic                  i_dfp_read;
  logic                  i_dfp_write;
  logic [DATA_WIDTH-1:0] i_dfp_wdata;
  logic [DATA_WIDTH-1:0] i_dfp_rdata;
  logic                  i_dfp_resp;

  logic [ADDR_WIDTH-1:0] d_dfp_addr;
  logic                  d_dfp_read;
  logic                  d_dfp_write;
  logic [DATA_WIDTH-1:0] d_dfp_wdata;
  logic [DATA_WIDTH-1:0] d_dfp_rdata;
  logic                  d_dfp_resp;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_read;
  logic                  mem_write;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_resp;

  logic                  arb_busy;
  logic                  arb_owner;

  modport slave (
    input  i_dfp_addr, i_dfp_read, i_dfp_write, i_dfp_wdata,
    output i_dfp_rdata, i_dfp_resp,
    input  d_dfp_addr, d_dfp_read, d_dfp_write, d_dfp_wdata,
    output d_dfp_rdata, d_dfp_resp,
    output mem_addr, mem_read, mem_write, mem_wdata,
    input  mem_rdata, mem_resp,
    output arb_busy, arb_owner
  );

  modport master (
    output i_dfp_addr, i_dfp_read, i_dfp_write, i_dfp_wdata,
    input  i_dfp_rdata, i_dfp_resp,
    output d_dfp_addr, d_dfp_read, d_dfp_write, d_dfp_wdata,
    input  d_dfp_rdata, d_dfp_resp,
    input  mem_addr, mem_read, mem_write, mem_wdata,
    output mem_rdata, mem_resp,
    input  arb_busy, arb_owner
  );
endinterface

// File: rtl/cache_dfp_arbiter.sv
// Shares one cacheline_adapter port between I-cache and D-cache; grant held until mem_resp.
// Tie-break: ARB_ROUND_ROBIN_EN defined -> alternate vs last grant; undefined -> D-cache wins.
module cache_dfp_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256
) (
  input  logic               clk,
  input  logic               rst,
  cache_dfp_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_e;

  state_e state_q, state_d;
  logic   rr_last_q, rr_last_d;
  logic   i_req, d_req, tie_pick_d;

  assign i_req = bus.i_dfp_read | bus.i_dfp_write;
  assign d_req = bus.d_dfp_read | bus.d_dfp_write;

`ifdef ARB_ROUND_ROBIN_EN
  assign tie_pick_d = ~rr_last_q;
`else
  assign tie_pick_d = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      rr_last_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    unique case (state_q)
      IDLE: begin
        if (i_req && d_req) state_d = tie_pick_d ? GRANT_D : GRANT_I;
        else if (d_req)     state_d = GRANT_D;
        else if (i_req)     state_d = GRANT_I;
        if (state_d != IDLE) rr_last_d = (state_d == GRANT_D);
      end
      GRANT_I, GRANT_D: begin
        if (bus.mem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Line-aligned address: the adapter always moves a whole 32-byte line.
  always_comb begin
    bus.mem_addr    = '0;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.mem_wdata   = '0;
    bus.i_dfp_resp  = 1'b0;
    bus.d_dfp_resp  = 1'b0;
    bus.i_dfp_rdata = bus.mem_rdata;
    bus.d_dfp_rdata = bus.mem_rdata;
    bus.arb_busy    = (state_q != IDLE);
    bus.arb_owner   = rr_last_q;
    unique case (state_q)
      GRANT_I: begin
        bus.mem_addr   = {bus.i_dfp_addr[ADDR_WIDTH-1:5], 5'b0};
        bus.mem_read   = bus.i_dfp_read;
        bus.mem_write  = bus.i_dfp_write;
        bus.mem_wdata  = bus.i_dfp_wdata;
        bus.i_dfp_resp = bus.mem_resp;
      end
      GRANT_D: begin
        bus.mem_addr   = {bus.d_dfp_addr[ADDR_WIDTH-1:5], 5'b0};
        bus.mem_read   = bus.d_dfp_read;
        bus.mem_write  = bus.d_dfp_write;
        bus.mem_wdata  = bus.d_dfp_wdata;
        bus.d_dfp_resp = bus.mem_resp;
      end
      default: ;
    endcase
  end

  i_rw_excl_a: assert property (@(posedge clk) disable iff (!rst)
    !(bus.i_dfp_read && bus.i_dfp_write));
  d_rw_excl_a: assert property (@(posedge clk) disable iff (!rst)
    !(bus.d_dfp_read && bus.d_dfp_write));
endmodule

// File: tb/tb_cache_dfp_arbiter.sv
// Self-checking bench for cache_dfp_arbiter: directed table, hand sequences, random vs model.
// Tie expectations follow ARB_ROUND_ROBIN_EN when the bench is built with it.
module tb_cache_dfp_arbiter;
  localparam int AW = 32;
  localparam int DW = 256;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam logic [AW-1:0] I_ADDR  = 32'h1eceb004;
  localparam logic [AW-1:0] I_LINE  = 32'h1eceb000;
  localparam logic [AW-1:0] D_ADDR  = 32'h0000_1040;
  localparam logic [DW-1:0] D_WDATA = {8{32'hdeadbeef}};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cache_dfp_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();
  cache_dfp_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: whether a line transfer is outstanding and who last won.
  bit m_busy = 1'b0;
  bit m_last = 1'b0;

  typedef struct packed {
    bit ir, dr, resp;
    bit e_busy, e_owner, e_mrd, e_iresp, e_dresp;
    logic [AW-1:0] e_addr;
  } vec_t;
  vec_t tbl [10];

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] v;
    for (int w = 0; w < DW / 32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_model(string tag);
    logic e_rd, e_wr, e_ir, e_dr;
    logic [AW-1:0] a;
    logic [DW-1:0] e_wd;
    e_rd = 1'b0; e_wr = 1'b0; e_ir = 1'b0; e_dr = 1'b0; a = '0; e_wd = '0;
    if (m_busy && rst) begin
      if (m_last) begin
        e_rd = bus.d_dfp_read; e_wr = bus.d_dfp_write; a = bus.d_dfp_addr; e_wd = bus.d_dfp_wdata;
      end else begin
        e_rd = bus.i_dfp_read; e_wr = bus.i_dfp_write; a = bus.i_dfp_addr; e_wd = bus.i_dfp_wdata;
      end
      a    = a - (a % 32);
      e_ir = !m_last && bus.mem_resp;
      e_dr = m_last && bus.mem_resp;
    end
    chk({tag, ".mem_read"},  DW'(bus.mem_read),  DW'(e_rd));
    chk({tag, ".mem_write"}, DW'(bus.mem_write), DW'(e_wr));
    chk({tag, ".mem_addr"},  DW'(bus.mem_addr),  DW'(a));
    chk({tag, ".mem_wdata"}, bus.mem_wdata, e_wd);
    chk({tag, ".i_resp"},    DW'(bus.i_dfp_resp), DW'(e_ir));
    chk({tag, ".d_resp"},    DW'(bus.d_dfp_resp), DW'(e_dr));
    chk({tag, ".i_rdata"},   bus.i_dfp_rdata, bus.mem_rdata);
    chk({tag, ".d_rdata"},   bus.d_dfp_rdata, bus.mem_rdata);
    chk({tag, ".busy"},      DW'(bus.arb_busy),  DW'(m_busy && rst));
    chk({tag, ".owner"},     DW'(bus.arb_owner), DW'(m_last));
  endtask

  task automatic settle(string tag);
    #2;
    check_model(tag);
  endtask

  task automatic clock_edge();
    bit ri, rd;
    @(posedge clk);
    ri = bus.i_dfp_read | bus.i_dfp_write;
    rd = bus.d_dfp_read | bus.d_dfp_write;
    if (!rst) begin
      m_busy = 1'b0; m_last = 1'b0;
    end else if (!m_busy) begin
      if (ri && rd) begin
        m_last = RR ? !m_last : 1'b1;
        m_busy = 1'b1;
      end else if (ri || rd) begin
        m_last = rd;
        m_busy = 1'b1;
      end
    end else if (bus.mem_resp) begin
      m_busy = 1'b0;
    end
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_dfp_read = 1'b0; bus.i_dfp_write = 1'b0;
    bus.d_dfp_read = 1'b0; bus.d_dfp_write = 1'b0;
    bus.mem_resp = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0; m_busy = 1'b0; m_last = 1'b0;
    clock_edge();
    rst = 1'b1;
  endtask

  initial begin
    bus.i_dfp_addr = I_ADDR; bus.i_dfp_wdata = rand_line();
    bus.d_dfp_addr = D_ADDR; bus.d_dfp_wdata = D_WDATA;
    bus.mem_rdata = '0;
    clear_inputs();

    // Reset held with random request activity.
    for (int k = 0; k < 3; k++) begin
      bus.i_dfp_read = 1'($urandom); bus.d_dfp_write = 1'($urandom);
      bus.mem_resp = 1'($urandom); bus.mem_rdata = rand_line();
      settle("t1_reset");
      clock_edge();
    end
    clear_inputs();
    rst = 1'b1;

    // I-cache read, adapter answers after 10 cycles.
    bus.i_dfp_read = 1'b1;
    settle("t2_idle");
    chk("t2_idle_mem_read", DW'(bus.mem_read), '0);
    clock_edge();
    for (int k = 1; k <= 10; k++) begin
      bus.mem_resp = (k == 10); bus.mem_rdata = rand_line();
      settle("t2_grant");
      chk("t2_mem_addr", DW'(bus.mem_addr), DW'(I_LINE));
      chk("t2_i_resp", DW'(bus.i_dfp_resp), DW'(k == 10));
      chk("t2_d_resp", DW'(bus.d_dfp_resp), '0);
      chk("t2_i_rdata", bus.i_dfp_rdata, bus.mem_rdata);
      clock_edge();
    end
    clear_inputs();
    settle("t2_after");
    chk("t2_after_busy", DW'(bus.arb_busy), '0);
    clock_edge();

    // D-cache write.
    bus.d_dfp_write = 1'b1;
    settle("t3_idle");
    clock_edge();
    for (int k = 1; k <= 4; k++) begin
      bus.mem_resp = (k == 4);
      settle("t3_grant");
      chk("t3_mem_write", DW'(bus.mem_write), DW'(1));
      chk("t3_mem_wdata", bus.mem_wdata, D_WDATA);
      chk("t3_d_resp", DW'(bus.d_dfp_resp), DW'(k == 4));
      chk("t3_i_resp", DW'(bus.i_dfp_resp), '0);
      clock_edge();
    end
    clear_inputs();
    settle("t3_after");
    chk("t3_after_busy", DW'(bus.arb_busy), '0);
    clock_edge();

    // Tie rounds from reset (last grant = I), then mem_resp while idle.
    tbl[0] = '{1, 1, 0, 0, 0, 0, 0, 0, 32'h0};
    tbl[1] = '{1, 1, 0, 1, 1, 1, 0, 0, D_ADDR};
    tbl[2] = '{1, 1, 1, 1, 1, 1, 0, 1, D_ADDR};
    tbl[3] = '{1, 1, 0, 0, 1, 0, 0, 0, 32'h0};
    tbl[4] = '{1, 1, 0, 1, !RR, 1, 0, 0, RR ? I_LINE : D_ADDR};
    tbl[5] = '{1, 1, 1, 1, !RR, 1, RR, !RR, RR ? I_LINE : D_ADDR};
    tbl[6] = '{1, 1, 0, 0, !RR, 0, 0, 0, 32'h0};
    tbl[7] = '{1, 1, 1, 1, 1, 1, 0, 1, D_ADDR};
    tbl[8] = '{0, 0, 1, 0, 1, 0, 0, 0, 32'h0};
    tbl[9] = '{0, 0, 0, 0, 1, 0, 0, 0, 32'h0};
    do_reset();
    for (int r = 0; r < 10; r++) begin
      bus.i_dfp_read = tbl[r].ir; bus.d_dfp_read = tbl[r].dr;
      bus.mem_resp = tbl[r].resp; bus.mem_rdata = rand_line();
      settle($sformatf("t4[%0d]", r));
      chk($sformatf("t4[%0d].busy", r),  DW'(bus.arb_busy),   DW'(tbl[r].e_busy));
      chk($sformatf("t4[%0d].owner", r), DW'(bus.arb_owner),  DW'(tbl[r].e_owner));
      chk($sformatf("t4[%0d].mrd", r),   DW'(bus.mem_read),   DW'(tbl[r].e_mrd));
      chk($sformatf("t4[%0d].iresp", r), DW'(bus.i_dfp_resp), DW'(tbl[r].e_iresp));
      chk($sformatf("t4[%0d].dresp", r), DW'(bus.d_dfp_resp), DW'(tbl[r].e_dresp));
      chk($sformatf("t4[%0d].addr", r),  DW'(bus.mem_addr),   DW'(tbl[r].e_addr));
      clock_edge();
    end
    clear_inputs();

    // Late D arrival while I holds the grant.
    bus.i_dfp_read = 1'b1;
    settle("t5_idle");
    clock_edge();
    for (int k = 1; k <= 5; k++) begin
      if (k == 2) bus.d_dfp_read = 1'b1;
      bus.mem_resp = (k == 5);
      settle("t5_grant_i");
      chk("t5_owner_i", DW'(bus.arb_owner), '0);
      chk("t5_busy_i", DW'(bus.arb_busy), DW'(1));
      chk("t5_d_resp", DW'(bus.d_dfp_resp), '0);
      clock_edge();
    end
    bus.i_dfp_read = 1'b0; bus.mem_resp = 1'b0;
    settle("t5_bubble");
    chk("t5_bubble_busy", DW'(bus.arb_busy), '0);
    clock_edge();
    settle("t5_grant_d");
    chk("t5_owner_d", DW'(bus.arb_owner), DW'(1));
    chk("t5_addr_d", DW'(bus.mem_addr), DW'(D_ADDR));
    bus.mem_resp = 1'b1;
    clock_edge();
    clear_inputs();
    settle("t5_done");
    clock_edge();

    // Reset asserted during a D grant; pending request re-granted after release.
    bus.d_dfp_read = 1'b1;
    settle("t6_idle");
    clock_edge();
    settle("t6_grant");
    chk("t6_grant_busy", DW'(bus.arb_busy), DW'(1));
    rst = 1'b0; m_busy = 1'b0; m_last = 1'b0;
    #1;
    chk("t6_rst_mem_read", DW'(bus.mem_read), '0);
    chk("t6_rst_busy", DW'(bus.arb_busy), '0);
    check_model("t6_rst");
    clock_edge();
    rst = 1'b1;
    settle("t6_release");
    clock_edge();
    settle("t6_regrant");
    chk("t6_regrant_busy", DW'(bus.arb_busy), DW'(1));
    chk("t6_regrant_owner", DW'(bus.arb_owner), DW'(1));
    bus.mem_resp = 1'b1;
    clock_edge();
    clear_inputs();

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(3) == 0) begin
        int c = $urandom_range(2);
        bus.i_dfp_read = (c == 1); bus.i_dfp_write = (c == 2);
        bus.i_dfp_addr = $urandom; bus.i_dfp_wdata = rand_line();
      end
      if ($urandom_range(3) == 0) begin
        int c = $urandom_range(2);
        bus.d_dfp_read = (c == 1); bus.d_dfp_write = (c == 2);
        bus.d_dfp_addr = $urandom; bus.d_dfp_wdata = rand_line();
      end
      bus.mem_resp  = ($urandom_range(3) == 0);
      bus.mem_rdata = rand_line();
      settle("rnd");
      clock_edge();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
